// File: rtl/mxv_cmd_parser_if.sv
// Byte-stream input and field-output handshake bundle for the hex command parser.
interface mxv_cmd_parser_if #(
  parameter int VAL_W = 8
) ();
  typedef logic [7:0] data_uart_t;

  data_uart_t       rx_data;
  logic             rx_valid;
  logic             out_ready;
  logic [VAL_W-1:0] out_value;
  logic             out_valid;
  logic             out_last;
  logic             err;

  modport master (
    output rx_data, rx_valid, out_ready,
    input  out_value, out_valid, out_last, err
  );

  modport slave (
    input  rx_data, rx_valid, out_ready,
    output out_value, out_valid, out_last, err
  );
endinterface

// File: rtl/mxv_cmd_parser.sv
// Parses ASCII hex fields separated by '_' and terminated by CR into values
// with a valid/ready output; malformed input pulses err and drops to the next CR.
module mxv_cmd_parser #(
  parameter int MAX_DIGITS = 2,
  parameter int VAL_W      = 4*MAX_DIGITS
) (
  input  logic           clk,
  input  logic           rst,
  mxv_cmd_parser_if.slave bus
);
  localparam int ACC_W = 4*MAX_DIGITS;
  localparam int CNT_W = $clog2(MAX_DIGITS+1);

  typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [ACC_W+3:0] acc_shift;
  logic [3:0]       dval;
  logic             is_digit, is_sep, is_eof;
  logic             full, can_emit, hs, emit, err_nx;

  function automatic logic [4:0] decode_hex(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return {1'b1, 4'(b - 8'h30)};
    if (b >= 8'h41 && b <= 8'h46) return {1'b1, 4'(b - 8'h37)};
    return 5'd0;
  endfunction

  always_comb begin
    {is_digit, dval} = decode_hex(bus.rx_data);
    is_sep = (bus.rx_data == 8'h5F);
    is_eof = (bus.rx_data == 8'h0D);
  end

  assign acc_shift = {acc, dval};
  assign full      = (count == CNT_W'(MAX_DIGITS));
  assign hs        = bus.out_valid & bus.out_ready;
  // A new field may only land if the output slot is empty or being accepted now.
  assign can_emit  = !bus.out_valid | bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.rx_valid) begin
      unique case (state)
        IDLE: begin
          if (is_digit)      state_nx = ACCUM;
          else if (!is_eof)  state_nx = DISCARD;
        end
        ACCUM: begin
          if (is_digit)                state_nx = full ? DISCARD : ACCUM;
          else if (is_sep || is_eof)   state_nx = can_emit ? IDLE : DISCARD;
          else                         state_nx = DISCARD;
        end
        DISCARD: begin
          if (is_eof) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_nx   = acc;
    count_nx = count;
    emit     = 1'b0;
    err_nx   = 1'b0;
    if (bus.rx_valid) begin
      unique case (state)
        IDLE: begin
          if (is_digit) begin
            acc_nx   = acc_shift[ACC_W-1:0];
            count_nx = count + 1'b1;
          end else if (!is_eof) begin
            err_nx = 1'b1;
          end
        end
        ACCUM: begin
          if (is_digit && !full) begin
            acc_nx   = acc_shift[ACC_W-1:0];
            count_nx = count + 1'b1;
          end else begin
            acc_nx   = '0;
            count_nx = '0;
            if ((is_sep || is_eof) && can_emit) emit   = 1'b1;
            else                                err_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      count         <= '0;
      bus.err       <= 1'b0;
      bus.out_value <= '0;
      bus.out_last  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      acc     <= acc_nx;
      count   <= count_nx;
      bus.err <= err_nx;
      if (emit) begin
        bus.out_value <= VAL_W'(acc);
        bus.out_last  <= is_eof;
        bus.out_valid <= 1'b1;
      end else if (hs) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mxv_cmd_parser.sv
// Byte-level bench for mxv_cmd_parser: vector table plus hand-written
// backpressure and async-reset sequences, with a queue scoreboard on the output.
module tb_mxv_cmd_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mxv_cmd_parser_if #(.VAL_W(8)) bus ();

  mxv_cmd_parser #(.MAX_DIGITS(2), .VAL_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] val;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    bit         rdy;
    bit         push;
    logic [7:0] val;
    bit         last;
    bit         err;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: observe a handshake just before the edge, then step past the edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", {bus.out_value, bus.out_last}, 9'h1FF);
      end else begin
        e = q.pop_front();
        chk("sb_value", bus.out_value, e.val);
        chk("sb_last", bus.out_last, e.last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit rdy, input bit push,
                      input logic [7:0] val, input bit last, input bit err);
    chk("err_idle", bus.err, 1'b0);
    bus.rx_data   = b;
    bus.rx_valid  = 1'b1;
    bus.out_ready = rdy;
    if (push) q.push_back('{val: val, last: last});
    tick();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h31;
    chk("err", bus.err, err);
    if (push) begin
      chk("lat_valid", bus.out_valid, 1'b1);
      chk("lat_value", bus.out_value, val);
      chk("lat_last", bus.out_last, last);
    end else if (rdy) begin
      chk("no_output", bus.out_valid, 1'b0);
    end
    tick();
    chk("err_clear", bus.err, 1'b0);
  endtask

  task automatic add(input logic [7:0] b, input bit rdy, input bit push,
                     input logic [7:0] val, input bit last, input bit err);
    vecs.push_back('{b: b, rdy: rdy, push: push, val: val, last: last, err: err});
  endtask

  localparam logic [7:0] CR = 8'h0D;

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state, checked before any clock edge and after a few edges.
    #2;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_value", bus.out_value, 8'h00);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid2", bus.out_valid, 1'b0);

    // "3F_07\r"
    add("3", 1, 0, 8'h00, 0, 0); add("F", 1, 0, 8'h00, 0, 0);
    add("_", 1, 1, 8'h3F, 0, 0); add("0", 1, 0, 8'h00, 0, 0);
    add("7", 1, 0, 8'h00, 0, 0); add(CR,  1, 1, 8'h07, 1, 0);
    // Overlong field, discard, then a clean frame
    add("1", 1, 0, 8'h00, 0, 0); add("2", 1, 0, 8'h00, 0, 0);
    add("3", 1, 0, 8'h00, 0, 1); add("5", 1, 0, 8'h00, 0, 0);
    add(CR,  1, 0, 8'h00, 0, 0); add("A", 1, 0, 8'h00, 0, 0);
    add(CR,  1, 1, 8'h0A, 1, 0);
    // Bad or empty field at frame start
    add("a", 1, 0, 8'h00, 0, 1); add(CR,  1, 0, 8'h00, 0, 0);
    add("_", 1, 0, 8'h00, 0, 1); add(CR,  1, 0, 8'h00, 0, 0);
    add(CR,  1, 0, 8'h00, 0, 0);
    // Character-class boundaries
    add("9", 1, 0, 8'h00, 0, 0); add(CR,  1, 1, 8'h09, 1, 0);
    add("B", 1, 0, 8'h00, 0, 0); add("E", 1, 0, 8'h00, 0, 0);
    add(CR,  1, 1, 8'hBE, 1, 0);
    add(":", 1, 0, 8'h00, 0, 1); add(CR,  1, 0, 8'h00, 0, 0);
    add("@", 1, 0, 8'h00, 0, 1); add(CR,  1, 0, 8'h00, 0, 0);
    add("G", 1, 0, 8'h00, 0, 1); add(CR,  1, 0, 8'h00, 0, 0);
    add("4", 1, 0, 8'h00, 0, 0); add("/", 1, 0, 8'h00, 0, 1);
    add(CR,  1, 0, 8'h00, 0, 0);
    add("0", 1, 0, 8'h00, 0, 0); add("_", 1, 1, 8'h00, 0, 0);
    add("C", 1, 0, 8'h00, 0, 0); add(CR,  1, 1, 8'h0C, 1, 0);
    // Held 0x11 accepted on the same edge that emits 0x22
    add("1", 0, 0, 8'h00, 0, 0); add("1", 0, 0, 8'h00, 0, 0);
    add("_", 0, 1, 8'h11, 0, 0); add("2", 0, 0, 8'h00, 0, 0);
    add("2", 0, 0, 8'h00, 0, 0); add("_", 1, 1, 8'h22, 0, 0);
    add(CR,  1, 0, 8'h00, 0, 0);

    foreach (vecs[i])
      send(vecs[i].b, vecs[i].rdy, vecs[i].push, vecs[i].val, vecs[i].last, vecs[i].err);

    // Overrun: 0x11 held, 0x22 dropped with err, single handshake afterwards
    send("1", 0, 0, 8'h00, 0, 0);
    send("1", 0, 0, 8'h00, 0, 0);
    send("_", 0, 1, 8'h11, 0, 0);
    send("2", 0, 0, 8'h00, 0, 0);
    send("2", 0, 0, 8'h00, 0, 0);
    send("_", 0, 0, 8'h00, 0, 1);
    chk("ovr_hold_valid", bus.out_valid, 1'b1);
    chk("ovr_hold_value", bus.out_value, 8'h11);
    send(CR, 0, 0, 8'h00, 0, 0);
    chk("ovr_hold_value2", bus.out_value, 8'h11);
    bus.out_ready = 1'b1;
    tick();
    chk("ovr_drained", bus.out_valid, 1'b0);
    repeat (3) tick();

    // Asynchronous reset mid-field with a held output
    send("5", 0, 0, 8'h00, 0, 0);
    send("_", 0, 0, 8'h00, 0, 0);
    chk("pre_rst_valid", bus.out_valid, 1'b1);
    chk("pre_rst_value", bus.out_value, 8'h05);
    send("4", 0, 0, 8'h00, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 1'b0);
    chk("arst_value", bus.out_value, 8'h00);
    chk("arst_last", bus.out_last, 1'b0);
    chk("arst_err", bus.err, 1'b0);
    #1 rst = 1'b0;
    send("_", 1, 0, 8'h00, 0, 1);
    send(CR, 1, 0, 8'h00, 0, 0);
    send("D", 1, 0, 8'h00, 0, 0);
    send(CR, 1, 1, 8'h0D, 1, 0);

    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("sb_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
